perip_bridge: RTL and testbench
===============================

Name: perip_bridge

Overview:
- Downstream of the CPU core's LSU peripheral port.
- Decodes perip_addr, routes loads and stores to the data RAM and to board MMIO registers, and returns perip_rdata.
- Owns the MMIO register file: LEDs, 7-seg, switch/key inputs, and a millisecond counter.
- All reads have a uniform 1-cycle latency, matching the synchronous DRAM.

Parameters:
- CLK_PER_MS, 50000, cpu_clk cycles per counter tick; must be >= 2.
- DRAM_AW, 16, DRAM word-address width (256 KiB).

Ports:
- cpu_clk  in  1  system clock
- cpu_rst  in  1  asynchronous active-high reset
- perip_addr  in  32  byte address from core
- perip_wen  in  1  store strobe
- perip_mask  in  2  00 byte, 01 half, 10 word (11 treated as word)
- perip_wdata  in  32  store data, lane-aligned by core
- perip_rdata  out  32  load data, valid 1 cycle after address
- dram_addr  out  DRAM_AW  word address to data RAM
- dram_wen  out  4  byte write enables
- dram_wdata  out  32  data to RAM
- dram_rdata  in  32  RAM output, 1-cycle synchronous read
- sw  in  24  board switches (asynchronous)
- key  in  5  board keys (asynchronous)
- led  out  24  LED register
- seg_wdata  out  32  7-seg display value
- bus_err  out  1  sticky unmapped-access flag

Behaviour:
- Address map, all other addresses unmapped:
  - DRAM: 0x8010_0000–0x8013_FFFF
  - SW: 0x8020_0000 (RO)
  - KEY: 0x8020_0010 (RO)
  - SEG: 0x8020_0020 (RW)
  - LED: 0x8020_0040 (RW)
  - CNT: 0x8020_0050 (RW)
- MMIO decode compares the full 32-bit word address.
- Reset (asynchronous): led=0, seg_wdata=0, perip_rdata=0, counter value=0, counter stopped, prescaler=0, synchronizers=0, bus_err=0.
- Byte enables: the low 2 address bits with the mask select enables.
  - byte: 4'b0001 << addr[1:0]
  - half: 4'b0011 << {addr[1],1'b0}
  - word: 4'b1111
  - Misaligned half/word accesses use the forced-aligned enables; no fault is raised.
- dram_wen = enables when perip_wen and DRAM is hit, else 0. dram_addr = perip_addr[DRAM_AW+1:2], combinational.
- MMIO stores: SEG and LED honour byte enables (led bits [31:24] discarded). Writes to SW and KEY are ignored.
- CNT is a command register, whole-word only:
  - Store 0x8000_0000: clear value to 0, clear prescaler, enter RUN.
  - Store 0xFFFF_FFFF: enter STOP, value held.
  - Any other CNT store is ignored.
- Counter state machine, states STOP/RUN:
  - In RUN, the prescaler counts 0..CLK_PER_MS-1. On wrap, value increments; value wraps 0xFFFF_FFFF -> 0.
  - A start command issued while already in RUN restarts from 0.
- Reads:
  - Cycle N: register the decoded select and, for MMIO, the MMIO read value.
  - Cycle N+1: perip_rdata = dram_rdata when DRAM was selected, else the registered MMIO value.
  - perip_rdata is always the full word; the core's LSU performs lane extraction.
  - A CNT read returns the value as of cycle N. A read in the same cycle as a tick returns the pre-increment value.
- Store and load in the same cycle at the same MMIO address: the read returns the old value.
- sw and key each pass through a 2-FF synchronizer; reads return the synchronized values, zero-extended.
- Unmapped accesses: stores are dropped, loads return the value defined by the optional feature.
- Back-to-back accesses every cycle are supported; there is no stall.

Optional Feature:
- Macro: PERIP_BUS_ERR_EN.
- Defined:
  - An unmapped load returns 0xDEAD_BEEF.
  - Any unmapped load or store sets bus_err, which stays set until reset.
- Undefined:
  - An unmapped load returns 0.
  - bus_err is tied to 0.

Test Plan:
- DRAM access:
  - Store word 0x1234_5678 to 0x8010_0004, then load it -> perip_rdata=0x1234_5678 one cycle after the load address.
  - Store byte 0xAB to 0x8010_0006 -> dram_wen=4'b0100; a following load returns 0x12AB_5678.
- LED byte write: store half 0xBEEF to 0x8020_0042 -> led=24'hEF_0000 (bit 24+ dropped); a load of 0x8020_0040 returns 0x00EF_0000.
- Counter, with CLK_PER_MS=4:
  - Write 0x8000_0000 to CNT, wait 40 cycles, read -> 10 (±1 by phase).
  - Write 0xFFFF_FFFF, wait 20 cycles -> the read is unchanged.
  - A second start -> the count restarts from 0.
- Switches: drive sw=24'h00_00A5 asynchronously, wait 3 cycles, load 0x8020_0000 -> 0x0000_00A5.
- Unmapped load at 0x9000_0000:
  - PERIP_BUS_ERR_EN defined -> rdata=0xDEAD_BEEF, bus_err=1, held after later valid accesses.
  - Macro undefined -> rdata=0, bus_err=0.
- Reset mid-run: assert cpu_rst while the counter is in RUN -> led, seg_wdata, and the counter clear immediately without a clock edge, and the counter is in STOP after release.

Source files
------------

// File: rtl/perip_bridge.sv
// Peripheral bridge: routes core loads/stores to data RAM and board MMIO registers with a uniform 1-cycle read latency.
// Optional macro PERIP_BUS_ERR_EN: unmapped loads return 0xDEAD_BEEF and any unmapped access sets a sticky bus_err.
module perip_bridge #(
  parameter int unsigned CLK_PER_MS = 50000,
  parameter int unsigned DRAM_AW    = 16
) (
  input  logic               cpu_clk,
  input  logic               cpu_rst,
  input  logic [31:0]        perip_addr,
  input  logic               perip_wen,
  input  logic [1:0]         perip_mask,
  input  logic [31:0]        perip_wdata,
  output logic [31:0]        perip_rdata,
  output logic [DRAM_AW-1:0] dram_addr,
  output logic [3:0]         dram_wen,
  output logic [31:0]        dram_wdata,
  input  logic [31:0]        dram_rdata,
  input  logic [23:0]        sw,
  input  logic [4:0]         key,
  output logic [23:0]        led,
  output logic [31:0]        seg_wdata,
  output logic               bus_err
);

  localparam logic [31:0] DRAM_LO  = 32'h8010_0000;
  localparam logic [31:0] DRAM_HI  = 32'h8013_FFFF;
  localparam logic [31:0] SW_ADDR  = 32'h8020_0000;
  localparam logic [31:0] KEY_ADDR = 32'h8020_0010;
  localparam logic [31:0] SEG_ADDR = 32'h8020_0020;
  localparam logic [31:0] LED_ADDR = 32'h8020_0040;
  localparam logic [31:0] CNT_ADDR = 32'h8020_0050;
  localparam logic [31:0] CMD_START = 32'h8000_0000;
  localparam logic [31:0] CMD_STOP  = 32'hFFFF_FFFF;
  localparam int unsigned PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_PER_MS - 1);

`ifdef PERIP_BUS_ERR_EN
  localparam logic [31:0] UNMAPPED_RDATA = 32'hDEAD_BEEF;
`else
  localparam logic [31:0] UNMAPPED_RDATA = 32'h0000_0000;
`endif

  typedef enum logic {CNT_STOP = 1'b0, CNT_RUN = 1'b1} cnt_state_e;

  logic hit_dram, hit_sw, hit_key, hit_seg, hit_led, hit_cnt, unmapped;
  logic [3:0] be;
  logic cmd_start, cmd_stop;

  cnt_state_e cnt_state_q, cnt_state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [23:0] led_q, led_d;
  logic [31:0] seg_q, seg_d;
  logic [23:0] sw_s1_q, sw_s2_q;
  logic [4:0] key_s1_q, key_s2_q;
  logic rd_dram_q;
  logic [31:0] mmio_rdata_q, mmio_rdata_d;

  // MMIO registers decode on the full word address; DRAM on a byte range.
  always_comb begin
    hit_dram = (perip_addr >= DRAM_LO) && (perip_addr <= DRAM_HI);
    hit_sw   = (perip_addr[31:2] == SW_ADDR[31:2]);
    hit_key  = (perip_addr[31:2] == KEY_ADDR[31:2]);
    hit_seg  = (perip_addr[31:2] == SEG_ADDR[31:2]);
    hit_led  = (perip_addr[31:2] == LED_ADDR[31:2]);
    hit_cnt  = (perip_addr[31:2] == CNT_ADDR[31:2]);
    unmapped = !(hit_dram || hit_sw || hit_key || hit_seg || hit_led || hit_cnt);
  end

  // Misaligned half/word accesses are silently forced to aligned lanes.
  always_comb begin
    case (perip_mask)
      2'b00:   be = 4'b0001 << perip_addr[1:0];
      2'b01:   be = 4'b0011 << {perip_addr[1], 1'b0};
      default: be = 4'b1111;
    endcase
  end

  assign dram_addr  = perip_addr[DRAM_AW+1:2];
  assign dram_wen   = (perip_wen && hit_dram) ? be : 4'b0000;
  assign dram_wdata = perip_wdata;

  always_comb begin
    led_d = led_q;
    seg_d = seg_q;
    for (int i = 0; i < 4; i++) begin
      if (perip_wen && hit_seg && be[i]) seg_d[8*i +: 8] = perip_wdata[8*i +: 8];
    end
    for (int i = 0; i < 3; i++) begin
      if (perip_wen && hit_led && be[i]) led_d[8*i +: 8] = perip_wdata[8*i +: 8];
    end
  end

  assign cmd_start = perip_wen && hit_cnt && (be == 4'b1111) && (perip_wdata == CMD_START);
  assign cmd_stop  = perip_wen && hit_cnt && (be == 4'b1111) && (perip_wdata == CMD_STOP);

  // Counter FSM: a start always restarts from zero, even while running.
  always_comb begin
    cnt_state_d = cnt_state_q;
    cnt_d       = cnt_q;
    presc_d     = presc_q;
    if (cmd_start) begin
      cnt_state_d = CNT_RUN;
      cnt_d       = 32'd0;
      presc_d     = '0;
    end else if (cmd_stop) begin
      cnt_state_d = CNT_STOP;
    end else if (cnt_state_q == CNT_RUN) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        cnt_d   = cnt_q + 32'd1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  // Read value is captured from current (pre-update) register state.
  always_comb begin
    mmio_rdata_d = 32'd0;
    if (hit_sw)        mmio_rdata_d = {8'd0, sw_s2_q};
    else if (hit_key)  mmio_rdata_d = {27'd0, key_s2_q};
    else if (hit_seg)  mmio_rdata_d = seg_q;
    else if (hit_led)  mmio_rdata_d = {8'd0, led_q};
    else if (hit_cnt)  mmio_rdata_d = cnt_q;
    else if (unmapped) mmio_rdata_d = UNMAPPED_RDATA;
  end

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      cnt_state_q  <= CNT_STOP;
      cnt_q        <= 32'd0;
      presc_q      <= '0;
      led_q        <= 24'd0;
      seg_q        <= 32'd0;
      sw_s1_q      <= 24'd0;
      sw_s2_q      <= 24'd0;
      key_s1_q     <= 5'd0;
      key_s2_q     <= 5'd0;
      rd_dram_q    <= 1'b0;
      mmio_rdata_q <= 32'd0;
    end else begin
      cnt_state_q  <= cnt_state_d;
      cnt_q        <= cnt_d;
      presc_q      <= presc_d;
      led_q        <= led_d;
      seg_q        <= seg_d;
      sw_s1_q      <= sw;
      sw_s2_q      <= sw_s1_q;
      key_s1_q     <= key;
      key_s2_q     <= key_s1_q;
      rd_dram_q    <= hit_dram;
      mmio_rdata_q <= mmio_rdata_d;
    end
  end

  assign perip_rdata = rd_dram_q ? dram_rdata : mmio_rdata_q;
  assign led         = led_q;
  assign seg_wdata   = seg_q;

`ifdef PERIP_BUS_ERR_EN
  logic bus_err_q;
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) bus_err_q <= 1'b0;
    else         bus_err_q <= bus_err_q | unmapped;
  end
  assign bus_err = bus_err_q;
`else
  assign bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_perip_bridge.sv
// Directed bench for perip_bridge: DRAM routing, MMIO registers, counter, synchronizers, unmapped access and async reset.
module tb_perip_bridge;

  localparam logic [31:0] SW_A  = 32'h8020_0000;
  localparam logic [31:0] KEY_A = 32'h8020_0010;
  localparam logic [31:0] SEG_A = 32'h8020_0020;
  localparam logic [31:0] LED_A = 32'h8020_0040;
  localparam logic [31:0] CNT_A = 32'h8020_0050;
  localparam logic [1:0] M_BYTE = 2'b00;
  localparam logic [1:0] M_HALF = 2'b01;
  localparam logic [1:0] M_WORD = 2'b10;

  logic        cpu_clk, cpu_rst;
  logic [31:0] perip_addr, perip_wdata, perip_rdata;
  logic        perip_wen;
  logic [1:0]  perip_mask;
  logic [15:0] dram_addr;
  logic [3:0]  dram_wen;
  logic [31:0] dram_wdata, dram_rdata;
  logic [23:0] sw, led;
  logic [4:0]  key;
  logic [31:0] seg_wdata;
  logic        bus_err;

  int n_vec, n_err;
  logic [31:0] mem [0:255];

  perip_bridge #(.CLK_PER_MS(4), .DRAM_AW(16)) dut (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
    .perip_addr(perip_addr), .perip_wen(perip_wen), .perip_mask(perip_mask),
    .perip_wdata(perip_wdata), .perip_rdata(perip_rdata),
    .dram_addr(dram_addr), .dram_wen(dram_wen), .dram_wdata(dram_wdata),
    .dram_rdata(dram_rdata), .sw(sw), .key(key), .led(led),
    .seg_wdata(seg_wdata), .bus_err(bus_err)
  );

  // clock / reset
  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  // synchronous byte-enabled data RAM model
  always @(posedge cpu_clk) begin
    for (int b = 0; b < 4; b++) begin
      if (dram_wen[b]) mem[dram_addr[7:0]][8*b +: 8] <= dram_wdata[8*b +: 8];
    end
    dram_rdata <= mem[dram_addr[7:0]];
  end

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic drive_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] m);
    perip_addr = a; perip_wdata = d; perip_mask = m; perip_wen = 1'b1;
    @(posedge cpu_clk); #1;
    perip_wen = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] a, output logic [31:0] rd);
    perip_addr = a; perip_wen = 1'b0; perip_mask = M_WORD;
    @(posedge cpu_clk); #1;
    rd = perip_rdata;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge cpu_clk); #1;
    n_vec++; if (led !== 24'd0) begin n_err++; $display("FAIL reset_led got=%h exp=%h", led, 24'd0); end
    n_vec++; if (seg_wdata !== 32'd0) begin n_err++; $display("FAIL reset_seg got=%h exp=%h", seg_wdata, 32'd0); end
    n_vec++; if (perip_rdata !== 32'd0) begin n_err++; $display("FAIL reset_rdata got=%h exp=%h", perip_rdata, 32'd0); end
    n_vec++; if (bus_err !== 1'b0) begin n_err++; $display("FAIL reset_bus_err got=%b exp=0", bus_err); end
    cpu_rst = 1'b0;
  endtask

  task automatic test_dram();
    logic [31:0] rd;
    perip_addr = 32'h8010_0004; perip_wdata = 32'h1234_5678; perip_mask = M_WORD; perip_wen = 1'b1;
    #1;
    n_vec++; if (dram_wen !== 4'b1111) begin n_err++; $display("FAIL dram_wen_word got=%b exp=1111", dram_wen); end
    n_vec++; if (dram_addr !== 16'd1) begin n_err++; $display("FAIL dram_addr got=%h exp=0001", dram_addr); end
    @(posedge cpu_clk); #1; perip_wen = 1'b0;
    do_load(32'h8010_0004, rd);
    n_vec++; if (rd !== 32'h1234_5678) begin n_err++; $display("FAIL dram_load_word got=%h exp=12345678", rd); end
    perip_addr = 32'h8010_0006; perip_wdata = 32'h00AB_0000; perip_mask = M_BYTE; perip_wen = 1'b1;
    #1;
    n_vec++; if (dram_wen !== 4'b0100) begin n_err++; $display("FAIL dram_wen_byte got=%b exp=0100", dram_wen); end
    @(posedge cpu_clk); #1; perip_wen = 1'b0;
    do_load(32'h8010_0004, rd);
    n_vec++; if (rd !== 32'h12AB_5678) begin n_err++; $display("FAIL dram_load_byte got=%h exp=12ab5678", rd); end
  endtask

  task automatic test_byte_enables();
    // misaligned accesses take the forced-aligned lanes; checked without letting an edge write
    perip_wen = 1'b1; perip_addr = 32'h8010_0007; perip_mask = M_HALF; #1;
    n_vec++; if (dram_wen !== 4'b1100) begin n_err++; $display("FAIL be_half_mis got=%b exp=1100", dram_wen); end
    perip_addr = 32'h8010_0005; perip_mask = M_WORD; #1;
    n_vec++; if (dram_wen !== 4'b1111) begin n_err++; $display("FAIL be_word_mis got=%b exp=1111", dram_wen); end
    perip_addr = 32'h8010_0003; perip_mask = M_BYTE; #1;
    n_vec++; if (dram_wen !== 4'b1000) begin n_err++; $display("FAIL be_byte3 got=%b exp=1000", dram_wen); end
    perip_mask = 2'b11; #1;
    n_vec++; if (dram_wen !== 4'b1111) begin n_err++; $display("FAIL be_mask11 got=%b exp=1111", dram_wen); end
    perip_addr = SEG_A; perip_mask = M_WORD; #1;
    n_vec++; if (dram_wen !== 4'b0000) begin n_err++; $display("FAIL be_mmio_dram_wen got=%b exp=0000", dram_wen); end
    perip_wen = 1'b0;
    @(posedge cpu_clk); #1;
  endtask

  task automatic test_led_seg();
    logic [31:0] rd;
    drive_store(32'h8020_0042, 32'hBEEF_0000, M_HALF);
    n_vec++; if (led !== 24'hEF_0000) begin n_err++; $display("FAIL led_half got=%h exp=ef0000", led); end
    do_load(LED_A, rd);
    n_vec++; if (rd !== 32'h00EF_0000) begin n_err++; $display("FAIL led_load got=%h exp=00ef0000", rd); end
    drive_store(SEG_A, 32'hCAFE_F00D, M_WORD);
    drive_store(32'h8020_0021, 32'h0000_1100, M_BYTE);
    n_vec++; if (seg_wdata !== 32'hCAFE_110D) begin n_err++; $display("FAIL seg_byte got=%h exp=cafe110d", seg_wdata); end
    do_load(SEG_A, rd);
    n_vec++; if (rd !== 32'hCAFE_110D) begin n_err++; $display("FAIL seg_load got=%h exp=cafe110d", rd); end
  endtask

  task automatic test_same_cycle_rw();
    drive_store(SEG_A, 32'h5555_AAAA, M_WORD);
    n_vec++; if (perip_rdata !== 32'hCAFE_110D) begin n_err++; $display("FAIL rw_old_value got=%h exp=cafe110d", perip_rdata); end
    n_vec++; if (seg_wdata !== 32'h5555_AAAA) begin n_err++; $display("FAIL rw_new_seg got=%h exp=5555aaaa", seg_wdata); end
  endtask

  task automatic test_counter();
    // start at edge E0; value after edge k is k/4, a read at edge k sees (k-1)/4
    drive_store(CNT_A, 32'h8000_0000, M_WORD);
    repeat (41) @(posedge cpu_clk); #1;
    n_vec++; if (perip_rdata !== 32'd10) begin n_err++; $display("FAIL cnt_run got=%0d exp=10", perip_rdata); end
    drive_store(CNT_A, 32'hFFFF_FFFF, M_WORD);
    repeat (20) @(posedge cpu_clk); #1;
    n_vec++; if (perip_rdata !== 32'd10) begin n_err++; $display("FAIL cnt_stop got=%0d exp=10", perip_rdata); end
    drive_store(CNT_A, 32'h1234_0000, M_WORD);
    repeat (8) @(posedge cpu_clk); #1;
    n_vec++; if (perip_rdata !== 32'd10) begin n_err++; $display("FAIL cnt_bad_cmd got=%0d exp=10", perip_rdata); end
    drive_store(CNT_A, 32'h8000_0000, M_WORD);
    n_vec++; if (perip_rdata !== 32'd10) begin n_err++; $display("FAIL cnt_start_old got=%0d exp=10", perip_rdata); end
    repeat (5) @(posedge cpu_clk); #1;
    n_vec++; if (perip_rdata !== 32'd1) begin n_err++; $display("FAIL cnt_restart got=%0d exp=1", perip_rdata); end
    drive_store(CNT_A, 32'h8000_0000, M_WORD);
    repeat (2) @(posedge cpu_clk); #1;
    n_vec++; if (perip_rdata !== 32'd0) begin n_err++; $display("FAIL cnt_restart_run got=%0d exp=0", perip_rdata); end
  endtask

  task automatic test_inputs();
    logic [31:0] rd;
    #2 sw = 24'h00_00A5; key = 5'h13;
    repeat (3) @(posedge cpu_clk); #1;
    do_load(SW_A, rd);
    n_vec++; if (rd !== 32'h0000_00A5) begin n_err++; $display("FAIL sw_load got=%h exp=000000a5", rd); end
    do_load(KEY_A, rd);
    n_vec++; if (rd !== 32'h0000_0013) begin n_err++; $display("FAIL key_load got=%h exp=00000013", rd); end
    drive_store(SW_A, 32'hFFFF_FFFF, M_WORD);
    do_load(SW_A, rd);
    n_vec++; if (rd !== 32'h0000_00A5) begin n_err++; $display("FAIL sw_ro got=%h exp=000000a5", rd); end
  endtask

  task automatic test_unmapped();
    logic [31:0] rd;
    logic [31:0] exp_rd;
    logic exp_err;
`ifdef PERIP_BUS_ERR_EN
    exp_rd = 32'hDEAD_BEEF; exp_err = 1'b1;
`else
    exp_rd = 32'h0000_0000; exp_err = 1'b0;
`endif
    do_load(32'h9000_0000, rd);
    n_vec++; if (rd !== exp_rd) begin n_err++; $display("FAIL unmapped_rdata got=%h exp=%h", rd, exp_rd); end
    n_vec++; if (bus_err !== exp_err) begin n_err++; $display("FAIL unmapped_bus_err got=%b exp=%b", bus_err, exp_err); end
    do_load(32'h8014_0000, rd);
    n_vec++; if (rd !== exp_rd) begin n_err++; $display("FAIL dram_edge_unmapped got=%h exp=%h", rd, exp_rd); end
    do_load(32'h8020_0044, rd);
    n_vec++; if (rd !== exp_rd) begin n_err++; $display("FAIL mmio_gap_unmapped got=%h exp=%h", rd, exp_rd); end
    drive_store(32'h8020_0044, 32'hFFFF_FFFF, M_WORD);
    n_vec++; if (led !== 24'hEF_0000) begin n_err++; $display("FAIL unmapped_store_led got=%h exp=ef0000", led); end
    do_load(LED_A, rd);
    n_vec++; if (rd !== 32'h00EF_0000) begin n_err++; $display("FAIL after_unmapped_led got=%h exp=00ef0000", rd); end
    n_vec++; if (bus_err !== exp_err) begin n_err++; $display("FAIL bus_err_sticky got=%b exp=%b", bus_err, exp_err); end
  endtask

  task automatic test_reset_mid_run();
    drive_store(LED_A, 32'h0012_3456, M_WORD);
    drive_store(SEG_A, 32'h8765_4321, M_WORD);
    drive_store(CNT_A, 32'h8000_0000, M_WORD);
    repeat (10) @(posedge cpu_clk); #2;
    cpu_rst = 1'b1; #1;
    n_vec++; if (led !== 24'd0) begin n_err++; $display("FAIL async_rst_led got=%h exp=000000", led); end
    n_vec++; if (seg_wdata !== 32'd0) begin n_err++; $display("FAIL async_rst_seg got=%h exp=00000000", seg_wdata); end
    n_vec++; if (perip_rdata !== 32'd0) begin n_err++; $display("FAIL async_rst_rdata got=%h exp=00000000", perip_rdata); end
    n_vec++; if (bus_err !== 1'b0) begin n_err++; $display("FAIL async_rst_bus_err got=%b exp=0", bus_err); end
    @(negedge cpu_clk); cpu_rst = 1'b0;
    perip_addr = CNT_A;
    repeat (9) @(posedge cpu_clk); #1;
    n_vec++; if (perip_rdata !== 32'd0) begin n_err++; $display("FAIL cnt_stopped_after_rst got=%0d exp=0", perip_rdata); end
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    dram_rdata = 32'd0;
    cpu_rst = 1'b1;
    perip_addr = 32'h8010_0000; perip_wen = 1'b0; perip_mask = M_WORD; perip_wdata = 32'd0;
    sw = 24'd0; key = 5'd0;
    test_reset();
    test_dram();
    test_byte_enables();
    test_led_seg();
    test_same_cycle_rw();
    test_counter();
    test_inputs();
    test_unmapped();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
